// File: rtl/hex_display_scan.sv
// Time-multiplexed hex scanner for a common-bus 7-segment display, with blanking gaps,
// optional leading-zero suppression and a double-buffered value that only swaps at frame start.
module hex_display_scan #(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  lz_blank,
    output logic [3:0]            data,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_next;
    logic                  idx_valid;
    logic                  wrap;
    logic                  boundary;
    logic [4*DIGITS-1:0]   shadow;
    logic [4*DIGITS-1:0]   shadow_next;
    logic [4*DIGITS-1:0]   pending;
    logic                  pending_valid;
    logic [3:0]            nibble;
    logic [DIGITS-1:0]     onehot;
    logic                  suppress;
    logic                  upper_zero;

    always_comb begin
        idx_valid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                idx_valid = 1'b1;
            end
        end
    end

    // Out-of-range digit indices are unreachable but are steered back to digit 0.
    always_comb begin
        wrap     = (cnt >= LAST_CNT);
        cnt_next = wrap ? '0 : cnt + 1'b1;
        if (!idx_valid) begin
            idx_next = '0;
        end else if (wrap) begin
            idx_next = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end else begin
            idx_next = idx;
        end
        boundary = (cnt_next == '0) && (idx_next == '0);
    end

    always_comb begin
        shadow_next = shadow;
        if (boundary) begin
            if (load) begin
                shadow_next = value;
            end else if (pending_valid) begin
                shadow_next = pending;
            end
        end
    end

    // Walk from the top digit down so upper_zero covers nibbles i..DIGITS-1 at each step.
    always_comb begin
        nibble     = '0;
        onehot     = '0;
        suppress   = 1'b0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (shadow_next[4*i +: 4] == 4'h0);
            if (idx_next == IW'(i)) begin
                nibble    = shadow_next[4*i +: 4];
                onehot[i] = 1'b1;
                suppress  = lz_blank && (i != 0) && upper_zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            idx           <= '0;
            shadow        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            data          <= '0;
            digit_en      <= '0;
            frame         <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            idx    <= idx_next;
            shadow <= shadow_next;
            if (load && !boundary) begin
                pending       <= value;
                pending_valid <= 1'b1;
            end else if (boundary) begin
                pending_valid <= 1'b0;
            end
            data     <= nibble;
            digit_en <= ((cnt_next >= BLANK_CNT) && !suppress) ? onehot : '0;
            frame    <= boundary;
        end
    end

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan (DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2); cycle 0 is the
// first cycle after reset, so frames start at multiples of 32.
module tb_hex_display_scan;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        lz_blank;
    logic [3:0]  data;
    logic [3:0]  digit_en;
    logic        frame;

    int cyc;
    int checkCount;
    int errorCount;

    hex_display_scan #(
        .DIGITS(4),
        .CLK_DIV(8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .value(value),
        .lz_blank(lz_blank),
        .data(data),
        .digit_en(digit_en),
        .frame(frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic advanceTo(input int n);
        while (cyc < n) tick();
    endtask

    task automatic expectAt(input int n, input logic [3:0] expData, input logic [3:0] expEn,
                            input logic expFrame);
        advanceTo(n);
        checkOutput($sformatf("c%0d data", n), 32'(data), 32'(expData));
        checkOutput($sformatf("c%0d digit_en", n), 32'(digit_en), 32'(expEn));
        checkOutput($sformatf("c%0d frame", n), 32'(frame), 32'(expFrame));
    endtask

    // Drives load for exactly the cycle numbered n, so it is sampled on the edge ending cycle n.
    task automatic applyStimulus(input int n, input logic [15:0] v);
        advanceTo(n);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        cyc        = 0;
        rst        = 1'b1;
        load       = 1'b0;
        value      = '0;
        lz_blank   = 1'b0;

        // Reset and first frame showing zeros, then 0x1234 from cycle 32
        doReset();
        expectAt(0, 4'h0, 4'b0000, 1'b0);
        expectAt(1, 4'h0, 4'b0000, 1'b0);
        expectAt(2, 4'h0, 4'b0001, 1'b0);
        applyStimulus(3, 16'h1234);
        expectAt(10, 4'h0, 4'b0010, 1'b0);
        expectAt(31, 4'h0, 4'b1000, 1'b0);
        expectAt(32, 4'h4, 4'b0000, 1'b1);
        expectAt(33, 4'h4, 4'b0000, 1'b0);
        expectAt(34, 4'h4, 4'b0001, 1'b0);
        expectAt(42, 4'h3, 4'b0010, 1'b0);
        expectAt(50, 4'h2, 4'b0100, 1'b0);
        expectAt(58, 4'h1, 4'b1000, 1'b0);
        expectAt(64, 4'h4, 4'b0000, 1'b1);

        // Leading-zero suppression of 0x0050 and 0x0000
        advanceTo(70);
        lz_blank = 1'b1;
        applyStimulus(70, 16'h0050);
        expectAt(96, 4'h0, 4'b0000, 1'b1);
        expectAt(98, 4'h0, 4'b0001, 1'b0);
        expectAt(106, 4'h5, 4'b0010, 1'b0);
        applyStimulus(110, 16'h0000);
        expectAt(114, 4'h0, 4'b0000, 1'b0);
        expectAt(119, 4'h0, 4'b0000, 1'b0);
        expectAt(122, 4'h0, 4'b0000, 1'b0);
        expectAt(127, 4'h0, 4'b0000, 1'b0);
        expectAt(130, 4'h0, 4'b0001, 1'b0);
        expectAt(138, 4'h0, 4'b0000, 1'b0);
        applyStimulus(140, 16'h1234);
        expectAt(146, 4'h0, 4'b0000, 1'b0);
        expectAt(154, 4'h0, 4'b0000, 1'b0);
        advanceTo(157);
        lz_blank = 1'b0;

        // Last load within a frame wins; current frame is untouched
        expectAt(160, 4'h4, 4'b0000, 1'b1);
        applyStimulus(170, 16'hABCD);
        expectAt(171, 4'h3, 4'b0010, 1'b0);
        applyStimulus(178, 16'h9999);
        expectAt(179, 4'h2, 4'b0100, 1'b0);
        expectAt(186, 4'h1, 4'b1000, 1'b0);
        expectAt(192, 4'h9, 4'b0000, 1'b1);
        expectAt(194, 4'h9, 4'b0001, 1'b0);
        expectAt(202, 4'h9, 4'b0010, 1'b0);
        expectAt(210, 4'h9, 4'b0100, 1'b0);
        expectAt(218, 4'h9, 4'b1000, 1'b0);

        // Load on the boundary edge bypasses pending and shows immediately
        applyStimulus(223, 16'h00F0);
        expectAt(224, 4'h0, 4'b0000, 1'b1);
        expectAt(226, 4'h0, 4'b0001, 1'b0);
        expectAt(234, 4'hF, 4'b0010, 1'b0);
        expectAt(242, 4'h0, 4'b0100, 1'b0);
        expectAt(250, 4'h0, 4'b1000, 1'b0);
        expectAt(256, 4'h0, 4'b0000, 1'b1);

        // lz_blank released mid-slot on suppressed digit 3 of 0x0007
        advanceTo(260);
        lz_blank = 1'b1;
        applyStimulus(260, 16'h0007);
        expectAt(288, 4'h7, 4'b0000, 1'b1);
        expectAt(290, 4'h7, 4'b0001, 1'b0);
        expectAt(314, 4'h0, 4'b0000, 1'b0);
        advanceTo(315);
        lz_blank = 1'b0;
        expectAt(315, 4'h0, 4'b0000, 1'b0);
        expectAt(316, 4'h0, 4'b1000, 1'b0);

        // Reset at cnt=5 of the digit-2 slot loses the displayed value
        expectAt(341, 4'h0, 4'b0100, 1'b0);
        doReset();
        expectAt(0, 4'h0, 4'b0000, 1'b0);
        expectAt(2, 4'h0, 4'b0001, 1'b0);
        expectAt(10, 4'h0, 4'b0010, 1'b0);
        expectAt(31, 4'h0, 4'b1000, 1'b0);
        expectAt(32, 4'h0, 4'b0000, 1'b1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/hex_display_scan.md
Name: hex_display_scan

Overview:
Time-multiplexed scanner for a multi-digit common-bus 7-segment display. It holds a packed hex value and steps through its nibbles one digit slot at a time. Each slot presents the current nibble on data[3:0] to the downstream hex-to-segment decoder and enables exactly one digit driver. It inserts a blanking gap at every digit change to prevent ghosting and can optionally suppress leading zeros. Double-buffered loading keeps the display free of tearing.

Parameters:
DIGITS, 4, number of digits scanned; legal range 1..8
CLK_DIV, 50000, clk cycles per digit slot; must be >= 2
BLANK_CYCLES, 500, cycles at the start of each slot with all digits disabled; must be < CLK_DIV

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
load  input  1  single-cycle strobe; captures value
value  input  4*DIGITS  packed hex value; nibble i (bits 4i+3..4i) belongs to digit i; digit 0 is rightmost
lz_blank  input  1  1 = suppress leading zero digits
data  output  4  nibble for the current slot, fed to the segment decoder
digit_en  output  DIGITS  one-hot digit enable, active-high; bit i = digit i
frame  output  1  one-cycle pulse on the first cycle of each new frame

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - data=0, digit_en=0, frame=0.
  - Slot counter cnt=0, digit index idx=0.
  - Displayed shadow=0, pending register=0, pending_valid=0.
- Slot timing:
  - cnt runs 0..CLK_DIV-1 and then wraps.
  - On wrap, idx advances. idx wraps DIGITS-1 -> 0, which is a frame boundary.
  - The first cycle after rst deasserts is cnt=0, idx=0.
- Output latency is zero relative to cnt. In the cycle where cnt=k:
  - data equals nibble idx of shadow, stable for the whole slot.
  - For k < BLANK_CYCLES: digit_en=0.
  - For k >= BLANK_CYCLES: digit_en = one-hot(idx), unless the digit is suppressed.
- Leading-zero suppression:
  - Applies when lz_blank=1, idx != 0, and nibbles idx..DIGITS-1 of shadow are all zero.
  - A suppressed digit has digit_en=0 for its entire slot. data is still driven normally.
  - Digit 0 is never suppressed.
  - lz_blank is sampled combinationally against shadow and may change at any time; it takes effect on the next cycle.
- Load and double buffering:
  - load=1 copies value into pending and sets pending_valid. Multiple loads within one frame: the last one wins.
  - At a frame boundary (the cycle entering idx=0, cnt=0): if pending_valid, shadow <= pending and pending_valid clears.
  - Load coinciding with the boundary cycle: value bypasses pending, goes straight into shadow, and is shown in the new frame. pending_valid clears.
  - The shadow never changes mid-frame.
- frame:
  - Asserted in the cycle where cnt=0 and idx=0, except the first cycle after reset.
  - Period is DIGITS*CLK_DIV cycles.
- Reset mid-slot: on the next edge all outputs go to their reset values and the displayed value is lost. Scanning restarts at digit 0.
- DIGITS=1: idx stays 0 and every slot is a frame boundary.
- Unused states: none. idx values >= DIGITS are unreachable, and the RTL forces them to 0.

Test Plan:
Bench parameters: DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.
1. Reset, then load 0x1234 at cycle 3.
   - First frame shows data=0 with digit_en=0001/0010/0100/1000 in cycles 2..7 of each slot.
   - From cycle 32: data=4,3,2,1 per slot, digit_en one-hot 0001,0010,0100,1000 in slot cycles 2..7 and 0000 in cycles 0..1.
   - frame pulses at cycles 32, 64, ...
2. lz_blank=1, value 0x0050 loaded.
   - Slots for digits 3 and 2 have digit_en=0000 throughout.
   - Digit 1 shows data=5; digit 0 shows data=0 with its enable on.
   - Value 0x0000 enables digit 0 only.
3. Displaying 0x1234, load 0xABCD during digit-1 slot, then 0x9999 during digit-2 slot.
   - The current frame finishes with 3,2,1.
   - The next frame shows 9,9,9,9. 0xABCD is never displayed.
4. load 0x00F0 asserted exactly on a frame-boundary cycle.
   - The frame starting in that cycle shows data=0,F,0,0 (digit 0 first).
   - No frame is delayed.
5. Assert rst for 1 cycle at cnt=5 of the digit-2 slot.
   - The next cycle has digit_en=0 and data=0.
   - Scanning restarts at digit 0 showing 0.
   - frame does not pulse until 32 cycles later.
6. Toggle lz_blank 1->0 mid-slot while displaying 0x0007 on the digit-3 slot.
   - digit_en goes 0000 -> 1000 one cycle after the toggle, provided cnt >= 2.
